csr_mach_irq: RTL and testbench

- Parametrised machine-mode CSR file with a multi-source prioritised interrupt controller.
- Sits beside the execute/writeback stage of the 3-stage core.
- Implements csrrw/csrrs/csrrc semantics, mstatus MIE/MPIE stacking, direct and vectored mtvec, writable mepc/mcause/mscratch, and a 64-bit mcycle counter.
- Produces a redirect (trap_taken, trap_pc) for interrupt entry and for mret.

---
 rtl/csr_mach_irq.sv | 236 +++++++++++++++++++++++
 tb/tb_csr_mach_irq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_mach_irq.sv
// ---------------------------------------------------------------------------
// csr_mach_irq
// Machine-mode CSR file with a prioritised multi-source interrupt controller.
// It sits beside the execute/writeback stage and redirects fetch on
// interrupt entry and on mret.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   csr_op        : 00 none, 01 RW, 10 RS, 11 RC
//   csr_rd_en     : the instruction reads the CSR (rd != x0)
//   csr_addr      : 12-bit CSR address
//   csr_wdata     : rs1 value or zero-extended uimm
//   csr_rdata     : pre-write CSR value (combinational)
//   csr_illegal   : access to an unimplemented address (combinational)
//   instr_valid   : a committing instruction is present this cycle
//   pc_i          : PC of the committing instruction
//   is_mret       : the committing instruction is mret
//   timer_irq     : MTIP source (level)
//   ext_irq       : MEIP source (level)
//   irq_i         : platform-local sources, irq_i[k] -> mip/mie bit 16+k
//   trap_taken    : redirect fetch this cycle
//   trap_pc       : redirect target
// ---------------------------------------------------------------------------
module csr_mach_irq #(
  parameter int          NUM_IRQ     = 4,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         csr_op,
  input  logic               csr_rd_en,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               instr_valid,
  input  logic [31:0]        pc_i,
  input  logic               is_mret,
  input  logic               timer_irq,
  input  logic               ext_irq,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_taken,
  output logic [31:0]        trap_pc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;

  // Writable bits of mie: MTIE, MEIE and one bit per local source.
  localparam logic [31:0] MIE_MASK =
    32'h0000_0880 | (((32'h1 << NUM_IRQ) - 32'h1) << 16);
  // mtvec bit1 is always 0; bit0 (vectored mode) only if vectoring exists.
  localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mip;
  logic [63:0] r_mcycle;

  logic [31:0] w_mstatus;
  logic [31:0] w_old;
  logic        w_hit;
  logic        w_access;
  logic [31:0] w_wval;
  logic        w_csr_we;
  logic [31:0] w_mip_next;
  logic [31:0] w_pending;
  logic [4:0]  w_cause;
  logic        w_take_irq;
  logic        w_do_mret;

  assign w_mstatus = {19'h0, 2'b11, 3'b000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};
  assign w_access  = csr_rd_en | (csr_op != 2'b00);

  // Read mux: current (pre-write) value of the addressed CSR and a hit flag.
  always_comb begin
    w_old = 32'h0;
    w_hit = 1'b1;
    case (csr_addr)
      A_MSTATUS:  w_old = w_mstatus;
      A_MIE:      w_old = r_mie;
      A_MTVEC:    w_old = r_mtvec;
      A_MSCRATCH: w_old = r_mscratch;
      A_MEPC:     w_old = r_mepc;
      A_MCAUSE:   w_old = r_mcause;
      A_MIP:      w_old = r_mip;
      A_MCYCLE:   w_old = r_mcycle[31:0];
      A_MCYCLEH:  w_old = r_mcycle[63:32];
      default: begin
        w_old = 32'h0;
        w_hit = 1'b0;
      end
    endcase
  end

  assign csr_rdata   = (w_access & w_hit) ? w_old : 32'h0;
  assign csr_illegal = w_access & ~w_hit;

  // Write value for the three CSR instruction flavours.
  always_comb begin
    w_wval = w_old;
    case (csr_op)
      2'b01:   w_wval = csr_wdata;
      2'b10:   w_wval = w_old | csr_wdata;
      2'b11:   w_wval = w_old & ~csr_wdata;
      default: w_wval = w_old;
    endcase
  end

  // Next mip image built from the raw level sources.
  always_comb begin
    w_mip_next     = 32'h0;
    w_mip_next[7]  = timer_irq;
    w_mip_next[11] = ext_irq;
    for (int k = 0; k < NUM_IRQ; k++) begin
      w_mip_next[16+k] = irq_i[k];
    end
  end

  assign w_pending = r_mip & r_mie;

  // Priority encoder: 11 beats 7 beats 16 beats 17 ... Scanning local lines
  // from high to low lets the lowest-numbered pending line win.
  always_comb begin
    w_cause = 5'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (w_pending[16+k]) begin
        w_cause = 5'(16 + k);
      end else begin
        w_cause = w_cause;
      end
    end
    if (w_pending[11]) begin
      w_cause = 5'd11;
    end else if (w_pending[7]) begin
      w_cause = 5'd7;
    end else begin
      w_cause = w_cause;
    end
  end

  // mret commits and wins over interrupt entry in the same cycle.
  assign w_do_mret  = instr_valid & is_mret;
  assign w_take_irq = r_mstatus_mie & (|w_pending) & instr_valid & ~is_mret;

  // Redirect generation: vectored mode adds 4*cause to the base.
  always_comb begin
    trap_taken = 1'b0;
    trap_pc    = 32'h0;
    if (w_take_irq) begin
      trap_taken = 1'b1;
      if (r_mtvec[0]) begin
        trap_pc = {r_mtvec[31:2], 2'b00} + {25'h0, w_cause, 2'b00};
      end else begin
        trap_pc = {r_mtvec[31:2], 2'b00};
      end
    end else if (w_do_mret) begin
      trap_taken = 1'b1;
      trap_pc    = r_mepc;
    end else begin
      trap_taken = 1'b0;
      trap_pc    = 32'h0;
    end
  end

  // A redirect in the same cycle discards the CSR write.
  assign w_csr_we = (csr_op != 2'b00) & w_hit & ~trap_taken;

  // CSR state: trap entry, mret stacking, then ordinary CSR writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'h0;
      r_mtvec        <= RESET_MTVEC & 32'hFFFF_FFFC;
      r_mscratch     <= 32'h0;
      r_mepc         <= 32'h0;
      r_mcause       <= 32'h0;
      r_mip          <= 32'h0;
    end else begin
      r_mip <= w_mip_next;
      if (w_take_irq) begin
        r_mepc         <= pc_i & 32'hFFFF_FFFC;
        r_mcause       <= {1'b1, 26'h0, w_cause};
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_do_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_csr_we) begin
        case (csr_addr)
          A_MSTATUS: begin
            r_mstatus_mie  <= w_wval[3];
            r_mstatus_mpie <= w_wval[7];
          end
          A_MIE:      r_mie      <= w_wval & MIE_MASK;
          A_MTVEC:    r_mtvec    <= w_wval & MTVEC_MASK;
          A_MSCRATCH: r_mscratch <= w_wval;
          A_MEPC:     r_mepc     <= w_wval & 32'hFFFF_FFFC;
          A_MCAUSE:   r_mcause   <= w_wval;
          default:    r_mcause   <= r_mcause;
        endcase
      end else begin
        r_mcause <= r_mcause;
      end
    end
  end

  // 64-bit cycle counter; a write to either half replaces it and skips the
  // increment for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle <= 64'h0;
    end else if (w_csr_we && (csr_addr == A_MCYCLE)) begin
      r_mcycle[31:0] <= w_wval;
    end else if (w_csr_we && (csr_addr == A_MCYCLEH)) begin
      r_mcycle[63:32] <= w_wval;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_mach_irq.sv
module tb_csr_mach_irq;

  localparam int NUM_IRQ = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         csr_op;
  logic               csr_rd_en;
  logic [11:0]        csr_addr;
  logic [31:0]        csr_wdata;
  logic [31:0]        csr_rdata;
  logic               csr_illegal;
  logic               instr_valid;
  logic [31:0]        pc_i;
  logic               is_mret;
  logic               timer_irq;
  logic               ext_irq;
  logic [NUM_IRQ-1:0] irq_i;
  logic               trap_taken;
  logic [31:0]        trap_pc;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  csr_mach_irq #(.NUM_IRQ(NUM_IRQ), .VECTORED_EN(1'b1), .RESET_MTVEC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_rd_en(csr_rd_en), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instr_valid(instr_valid), .pc_i(pc_i), .is_mret(is_mret), .timer_irq(timer_irq),
    .ext_irq(ext_irq), .irq_i(irq_i), .trap_taken(trap_taken), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_op      = 2'b00;
    csr_rd_en   = 1'b0;
    csr_wdata   = 32'h0;
    instr_valid = 1'b0;
    is_mret     = 1'b0;
  endtask

  task automatic drive_csr(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wd, input logic rd);
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
    csr_rd_en = rd;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    drive_csr(op, addr, wd, 1'b0);
    step();
    idle();
  endtask

  task automatic test_reset();
    exp_q.push_back(32'h0000_1800);
    drive_csr(2'b00, 12'h300, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL rst_mstatus: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h0);
    drive_csr(2'b00, 12'h305, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL rst_mtvec: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h0);
    drive_csr(2'b00, 12'h342, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL rst_mcause: got %h exp %h", csr_rdata, exp); end
    n_tests++;
    if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL rst_trap: got %b exp 0", trap_taken); end
    idle();
  endtask

  task automatic test_direct_irq();
    csr_wr(2'b01, 12'h305, 32'h0000_0100);
    csr_wr(2'b01, 12'h304, 32'h0000_0080);
    csr_wr(2'b10, 12'h300, 32'h0000_0008);
    timer_irq = 1'b1;
    step();
    exp_q.push_back(32'h0000_0100);
    instr_valid = 1'b1;
    pc_i        = 32'h40;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (trap_taken !== 1'b1 || trap_pc !== exp) begin
      n_fail++; $display("FAIL direct_entry: got taken=%b pc=%h exp taken=1 pc=%h", trap_taken, trap_pc, exp);
    end
    step();
    idle();
    timer_irq = 1'b0;
    exp_q.push_back(32'h0000_0040);
    drive_csr(2'b00, 12'h341, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL direct_mepc: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h8000_0007);
    drive_csr(2'b00, 12'h342, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL direct_mcause: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h0000_1880);
    drive_csr(2'b00, 12'h300, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL direct_mstatus: got %h exp %h", csr_rdata, exp); end
    idle();
    step();
  endtask

  task automatic test_vectored();
    csr_wr(2'b01, 12'h305, 32'h0000_0101);
    csr_wr(2'b01, 12'h304, 32'h0001_0880);
    csr_wr(2'b10, 12'h300, 32'h0000_0008);
    timer_irq = 1'b1;
    ext_irq   = 1'b1;
    irq_i     = 4'b0001;
    step();
    exp_q.push_back(32'h0000_012C);
    instr_valid = 1'b1;
    pc_i        = 32'h50;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (trap_taken !== 1'b1 || trap_pc !== exp) begin
      n_fail++; $display("FAIL vec_cause11: got taken=%b pc=%h exp taken=1 pc=%h", trap_taken, trap_pc, exp);
    end
    step();
    idle();
    ext_irq = 1'b0;
    exp_q.push_back(32'h8000_000B);
    drive_csr(2'b00, 12'h342, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL vec_mcause11: got %h exp %h", csr_rdata, exp); end
    idle();
    step();
    // mret back; afterwards timer (7) outranks local line 16
    exp_q.push_back(32'h0000_0050);
    instr_valid = 1'b1;
    is_mret     = 1'b1;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (trap_taken !== 1'b1 || trap_pc !== exp) begin
      n_fail++; $display("FAIL vec_mret: got taken=%b pc=%h exp taken=1 pc=%h", trap_taken, trap_pc, exp);
    end
    step();
    idle();
    exp_q.push_back(32'h0000_1888);
    drive_csr(2'b00, 12'h300, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL vec_mret_mstatus: got %h exp %h", csr_rdata, exp); end
    idle();
    exp_q.push_back(32'h0000_011C);
    instr_valid = 1'b1;
    pc_i        = 32'h60;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (trap_taken !== 1'b1 || trap_pc !== exp) begin
      n_fail++; $display("FAIL vec_cause7: got taken=%b pc=%h exp taken=1 pc=%h", trap_taken, trap_pc, exp);
    end
    step();
    idle();
  endtask

  task automatic test_mret_blocks();
    csr_wr(2'b10, 12'h300, 32'h0000_0008);
    exp_q.push_back(32'h0000_0060);
    instr_valid = 1'b1;
    is_mret     = 1'b1;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (trap_taken !== 1'b1 || trap_pc !== exp) begin
      n_fail++; $display("FAIL mret_block: got taken=%b pc=%h exp taken=1 pc=%h", trap_taken, trap_pc, exp);
    end
    step();
    idle();
    exp_q.push_back(32'h0000_011C);
    instr_valid = 1'b1;
    pc_i        = 32'h70;
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (trap_taken !== 1'b1 || trap_pc !== exp) begin
      n_fail++; $display("FAIL mret_next_take: got taken=%b pc=%h exp taken=1 pc=%h", trap_taken, trap_pc, exp);
    end
    step();
    idle();
    timer_irq = 1'b0;
    irq_i     = '0;
    step();
  endtask

  task automatic test_illegal();
    csr_wr(2'b01, 12'h340, 32'h1234_5678);
    exp_q.push_back(32'h0);
    drive_csr(2'b10, 12'h7C0, 32'hFFFF_FFFF, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_illegal !== 1'b1 || csr_rdata !== exp) begin
      n_fail++; $display("FAIL illegal_rs: got ill=%b rdata=%h exp ill=1 rdata=%h", csr_illegal, csr_rdata, exp);
    end
    step();
    idle();
    csr_addr = 12'h7C0;
    #1;
    n_tests++;
    if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_noaccess: got %b exp 0", csr_illegal); end
    exp_q.push_back(32'h1234_5678);
    drive_csr(2'b00, 12'h340, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_illegal !== 1'b0 || csr_rdata !== exp) begin
      n_fail++; $display("FAIL illegal_nochange: got ill=%b rdata=%h exp ill=0 rdata=%h", csr_illegal, csr_rdata, exp);
    end
    idle();
  endtask

  task automatic test_mip_readonly();
    timer_irq = 1'b1;
    irq_i     = 4'b1010;
    step();
    exp_q.push_back(32'h000A_0080);
    drive_csr(2'b01, 12'h344, 32'hFFFF_FFFF, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL mip_old: got %h exp %h", csr_rdata, exp); end
    step();
    idle();
    exp_q.push_back(32'h000A_0080);
    drive_csr(2'b00, 12'h344, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL mip_ro: got %h exp %h", csr_rdata, exp); end
    idle();
    timer_irq = 1'b0;
    irq_i     = '0;
    step();
  endtask

  task automatic test_rc_mie();
    csr_wr(2'b10, 12'h300, 32'h0000_0008);
    timer_irq = 1'b1;
    step();
    exp_q.push_back(32'h0000_1888);
    drive_csr(2'b11, 12'h300, 32'h0000_0008, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp || trap_taken !== 1'b0) begin
      n_fail++; $display("FAIL rc_cycle: got rdata=%h taken=%b exp rdata=%h taken=0", csr_rdata, trap_taken, exp);
    end
    step();
    idle();
    instr_valid = 1'b1;
    pc_i        = 32'h90;
    #1;
    n_tests++;
    if (trap_taken !== 1'b0 || trap_pc !== 32'h0) begin
      n_fail++; $display("FAIL rc_no_trap: got taken=%b pc=%h exp taken=0 pc=0", trap_taken, trap_pc);
    end
    step();
    idle();
    timer_irq = 1'b0;
    step();
  endtask

  task automatic test_mcycle();
    csr_wr(2'b01, 12'hB80, 32'h0000_0005);
    csr_wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    step();
    exp_q.push_back(32'h0000_0006);
    drive_csr(2'b00, 12'hB80, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL mcycle_carry_hi: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h0);
    drive_csr(2'b00, 12'hB00, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL mcycle_wrap_lo: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h3);
    step();
    step();
    step();
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL mcycle_count: got %h exp %h", csr_rdata, exp); end
    idle();
  endtask

  task automatic test_async_reset();
    csr_wr(2'b01, 12'h340, 32'hDEAD_BEEF);
    step();
    #2;
    rst = 1'b1;
    exp_q.push_back(32'h0);
    drive_csr(2'b00, 12'h340, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL arst_mscratch: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h0);
    drive_csr(2'b00, 12'hB80, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL arst_mcycleh: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h0);
    drive_csr(2'b00, 12'h304, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL arst_mie: got %h exp %h", csr_rdata, exp); end
    exp_q.push_back(32'h0000_1800);
    drive_csr(2'b00, 12'h300, 32'h0, 1'b1);
    #1;
    exp = exp_q.pop_front();
    n_tests++;
    if (csr_rdata !== exp) begin n_fail++; $display("FAIL arst_mstatus: got %h exp %h", csr_rdata, exp); end
    idle();
    #1;
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    csr_addr  = 12'h0;
    pc_i      = 32'h0;
    timer_irq = 1'b0;
    ext_irq   = 1'b0;
    irq_i     = '0;
    idle();
    #12;
    rst = 1'b0;
    step();
    test_reset();
    test_direct_irq();
    test_vectored();
    test_mret_blocks();
    test_illegal();
    test_mip_readonly();
    test_rc_mie();
    test_mcycle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
